// File: rtl/demodulator_psk.sv
// PSK receive path: line synchronizer, edge-aligned bit timing, sync-word hunt and an
// LSB-first symbol deserializer that feeds the RX FIFO write port.
module demodulator_psk #(
  parameter int          PSK_CLKS_PER_BIT    = 4,
  parameter int          PSK_BITS_PER_SYMBOL = 4,
  parameter int          SYNC_BITS           = 8,
  parameter logic [15:0] SYNC_WORD           = 16'h00A5,
  parameter int          FRAME_SYMBOLS       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       din,
  output logic [7:0] sample,
  input  logic       full,
  output logic       write,
  output logic       locked,
  output logic       overflow,
  output logic       bclk
);
  localparam int B   = PSK_BITS_PER_SYMBOL;
  localparam int SB  = SYNC_BITS;
  localparam int PW  = (PSK_CLKS_PER_BIT > 2) ? $clog2(PSK_CLKS_PER_BIT) : 1;
  localparam int BCW = $clog2(B + 1);
  localparam int FCW = (FRAME_SYMBOLS > 1) ? $clog2(FRAME_SYMBOLS + 1) : 1;

  localparam logic [PW-1:0]  PH_MAX  = PW'(PSK_CLKS_PER_BIT - 1);
  localparam logic [PW-1:0]  PH_MID  = PW'(PSK_CLKS_PER_BIT / 2);
  localparam logic [BCW-1:0] BC_LAST = BCW'(B - 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'((FRAME_SYMBOLS > 0) ? FRAME_SYMBOLS - 1 : 0);
  localparam logic [SB-1:0]  SYNC    = SYNC_WORD[SB-1:0];

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state, state_n;
  logic           din_m, din_s, din_d;
  logic           edge_det, s;
  logic [PW-1:0]  ph;
  logic [SB-1:0]  hunt, hunt_sh;
  logic [B-1:0]   sym, sym_sh, sym_cap;
  logic [BCW-1:0] bcnt;
  logic [FCW-1:0] fcnt;
  logic           done;
  logic           sync_hit, sym_last, frame_last;

  // din is asynchronous: two flops to settle, a third for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {din_m, din_s, din_d} <= 3'b000;
    else        {din_m, din_s, din_d} <= {din, din_m, din_s};
  end

  assign edge_det = din_s ^ din_d;
  assign s        = (ph == PH_MID) && !edge_det;

  always_comb begin
    hunt_sh         = hunt >> 1;
    hunt_sh[SB-1]   = din_s;
    sym_sh          = sym >> 1;
    sym_sh[B-1]     = din_s;
  end

  assign sync_hit   = (hunt_sh == SYNC);
  assign sym_last   = (bcnt == BC_LAST);
  assign frame_last = (FRAME_SYMBOLS != 0) && (fcnt == FC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = HUNT;
    end else begin
      case (state)
        HUNT:    if (s && sync_hit) state_n = LOCKED;
        LOCKED:  if (s && sym_last && frame_last) state_n = HUNT;
        default: state_n = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  // Completed symbols are parked in sym_cap so the FIFO push a cycle later never
  // races with the shift register picking up the next bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= '0;
      hunt     <= '0;
      sym      <= '0;
      sym_cap  <= '0;
      bcnt     <= '0;
      fcnt     <= '0;
      done     <= 1'b0;
      write    <= 1'b0;
      bclk     <= 1'b0;
      sample   <= '0;
      overflow <= 1'b0;
    end else if (!enable) begin
      ph    <= '0;
      hunt  <= '0;
      sym   <= '0;
      bcnt  <= '0;
      fcnt  <= '0;
      done  <= 1'b0;
      write <= 1'b0;
      bclk  <= 1'b0;
    end else begin
      ph    <= edge_det ? PW'(1) : ((ph == PH_MAX) ? '0 : ph + 1'b1);
      bclk  <= s;
      done  <= 1'b0;
      write <= 1'b0;
      if (done) begin
        if (!full) begin
          write  <= 1'b1;
          sample <= 8'(sym_cap);
        end else begin
          overflow <= 1'b1;
        end
      end
      if (s) begin
        if (state == HUNT) begin
          hunt <= hunt_sh;
          if (sync_hit) begin
            bcnt <= '0;
            sym  <= '0;
            fcnt <= '0;
          end
        end else begin
          sym <= sym_sh;
          if (sym_last) begin
            bcnt    <= '0;
            done    <= 1'b1;
            sym_cap <= sym_sh;
            fcnt    <= frame_last ? '0 : fcnt + 1'b1;
            if (frame_last) hunt <= '0;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demodulator_psk.sv
// Bench for demodulator_psk: bit-list reference model and scoreboard, two instances
// (unlimited frames and 2-symbol frames) driven by the same line.
module tb_demodulator_psk;
  localparam int         CLKS = 4;
  localparam int         BITS = 4;
  localparam logic [7:0] SW   = 8'hA5;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, din = 1'b1, full = 1'b0;
  logic [7:0] sample0, sample1;
  logic       write0, write1, locked0, locked1, ovf0, ovf1, bclk0, bclk1;

  always #5 clk = ~clk;

  demodulator_psk #(.PSK_CLKS_PER_BIT(CLKS), .PSK_BITS_PER_SYMBOL(BITS), .SYNC_BITS(8),
                    .SYNC_WORD(16'h00A5), .FRAME_SYMBOLS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .sample(sample0), .full(full),
    .write(write0), .locked(locked0), .overflow(ovf0), .bclk(bclk0));

  demodulator_psk #(.PSK_CLKS_PER_BIT(CLKS), .PSK_BITS_PER_SYMBOL(BITS), .SYNC_BITS(8),
                    .SYNC_WORD(16'h00A5), .FRAME_SYMBOLS(2)) u_dutf (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .sample(sample1), .full(full),
    .write(write1), .locked(locked1), .overflow(ovf1), .bclk(bclk1));

  int n_chk = 0, n_fail = 0;

  bit         tx_bit[$];
  bit         tx_full[$];
  int         tx_per[$];
  bit         cur_full, jit_on, jit_ph;
  logic [7:0] exp0[$], exp1[$], act0[$], act1[$];
  bit         exp_lk0, exp_lk1, ovf_exp0, ovf_exp1;
  int         lk1_falls;
  logic       pw0, pw1, pb0, pb1, pl1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void push_bit(input bit b);
    tx_bit.push_back(b);
    tx_full.push_back(cur_full);
    tx_per.push_back(jit_on ? (jit_ph ? 5 : 3) : CLKS);
    if (jit_on) jit_ph = !jit_ph;
  endfunction

  function automatic void add_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) push_bit(v[i]);
  endfunction

  // full for a symbol is raised from its second bit and held through the next symbol's first bit
  function automatic void add_sym(input logic [7:0] v, input bit f);
    for (int i = 0; i < BITS; i++) begin
      if (i == 1) cur_full = f;
      push_bit(v[i]);
    end
  endfunction

  // Reference: walk the list of line bits; the idle line before it reads as ones
  function automatic void model(input int frame, output logic [7:0] q[$], output bit lk, output bit ov);
    logic [7:0] win = 8'hFF;
    int nb = 0, nf = 0, val = 0;
    q = {}; lk = 0; ov = 0;
    for (int j = 0; j < tx_bit.size(); j++) begin
      bit b = tx_bit[j];
      bit f = (j + 1 < tx_full.size()) ? tx_full[j+1] : tx_full[j];
      if (!lk) begin
        win = {b, win[7:1]};
        if (win == SW) begin lk = 1; nb = 0; nf = 0; val = 0; end
      end else begin
        val = val + (int'(b) << nb);
        nb++;
        if (nb == BITS) begin
          if (f) ov = 1;
          else   q.push_back(8'(val));
          nf++; nb = 0; val = 0;
          if (frame != 0 && nf == frame) begin lk = 0; win = 8'h00; end
        end
      end
    end
  endfunction

  task automatic start_scn();
    logic [7:0] q0[$], q1[$];
    bit o0, o1;
    model(0, q0, exp_lk0, o0);
    model(2, q1, exp_lk1, o1);
    exp0 = q0; exp1 = q1;
    ovf_exp0 = ovf_exp0 | o0;
    ovf_exp1 = ovf_exp1 | o1;
    act0 = {}; act1 = {}; lk1_falls = 0;
    enable = 1'b0; din = 1'b1; full = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (10 * CLKS) @(negedge clk);
  endtask

  task automatic send(input int from, input int upto);
    for (int j = from; j < upto; j++) begin
      din  = tx_bit[j];
      full = tx_full[j];
      repeat (tx_per[j]) @(negedge clk);
    end
  endtask

  task automatic clear_tx();
    enable = 1'b0; full = 1'b0;
    tx_bit = {}; tx_full = {}; tx_per = {};
    cur_full = 0; jit_on = 0; jit_ph = 0;
    @(negedge clk);
  endtask

  // stop 7 clocks after the last bit starts: its write is out, the next sample is not taken
  task automatic end_scn(input string name);
    repeat (7 - tx_per[tx_per.size()-1]) @(negedge clk);
    check({name, " locked0"}, locked0, exp_lk0);
    check({name, " locked1"}, locked1, exp_lk1);
    check({name, " missing writes0"}, exp0.size(), 0);
    check({name, " missing writes1"}, exp1.size(), 0);
    check({name, " overflow0"}, ovf0, ovf_exp0);
    check({name, " overflow1"}, ovf1, ovf_exp1);
  endtask

  // per-cycle scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      pw0 <= 0; pw1 <= 0; pb0 <= 0; pb1 <= 0; pl1 <= 0;
    end else begin
      if (write0) begin
        act0.push_back(sample0);
        check("dut0 write pulse width", pw0, 0);
        if (exp0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dut0 unexpected write: got sample %0h, expected no write", sample0);
        end else check("dut0 sample", sample0, exp0.pop_front());
      end
      if (write1) begin
        act1.push_back(sample1);
        check("dut1 write pulse width", pw1, 0);
        if (exp1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dut1 unexpected write: got sample %0h, expected no write", sample1);
        end else check("dut1 sample", sample1, exp1.pop_front());
      end
      if (bclk0) check("dut0 bclk pulse width", pb0, 0);
      if (bclk1) check("dut1 bclk pulse width", pb1, 0);
      check("dut0 overflow not expected", ovf0 & ~ovf_exp0, 0);
      check("dut1 overflow not expected", ovf1 & ~ovf_exp1, 0);
      if (pl1 && !locked1 && enable) lk1_falls++;
      pw0 <= write0; pw1 <= write1; pb0 <= bclk0; pb1 <= bclk1; pl1 <= locked1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    repeat (3) @(negedge clk);
    check("reset sample0", sample0, 0);
    check("reset write0", write0, 0);
    check("reset locked0", locked0, 0);
    check("reset overflow0", ovf0, 0);
    check("reset bclk0", bclk0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: sync then nibbles 3, C
    add_bits(SW, 8); add_sym(8'h03, 0); add_sym(8'h0C, 0);
    start_scn();
    check("t1 model writes", exp0.size(), 2);
    send(0, tx_bit.size());
    end_scn("t1");
    check("t1 write count", act0.size(), 2);
    check("t1 first sample", act0[0], 8'h03);
    check("t1 second sample", act0[1], 8'h0C);
    check("t1 locked", locked0, 1);
    clear_tx();

    // 2: misaligned pattern and filler must not lock; sync afterwards does
    add_bits(32'h66666666, 32); add_bits(32'h66666666, 32); add_bits(8'hFF, 8);
    idx = tx_bit.size();
    add_bits(SW, 8);
    start_scn();
    send(0, idx);
    check("t2 no lock on noise0", locked0, 0);
    check("t2 no lock on noise1", locked1, 0);
    send(idx, tx_bit.size());
    end_scn("t2");
    check("t2 locked after sync", locked0, 1);
    check("t2 no writes", act0.size(), 0);
    clear_tx();

    // 3: second symbol dropped by a full FIFO
    add_bits(SW, 8); add_sym(8'h01, 0); add_sym(8'h02, 1); add_sym(8'h03, 0);
    start_scn();
    send(0, tx_bit.size());
    end_scn("t3");
    check("t3 write count", act0.size(), 2);
    check("t3 first sample", act0[0], 8'h01);
    check("t3 second sample", act0[1], 8'h03);
    check("t3 overflow sticky", ovf0, 1);
    clear_tx();

    // 6: asynchronous reset mid-symbol
    add_bits(SW, 8); add_sym(8'h07, 0);
    start_scn();
    send(0, 10);
    check("t6 locked before reset", locked0, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6 async sample0", sample0, 0);
    check("t6 async overflow0", ovf0, 0);
    check("t6 async locked0", locked0, 0);
    check("t6 async locked1", locked1, 0);
    check("t6 async sample1", sample1, 0);
    check("t6 async overflow1", ovf1, 0);
    check("t6 async write/bclk", {write0, write1, bclk0, bclk1}, 0);
    exp0 = {}; exp1 = {}; act0 = {}; act1 = {};
    ovf_exp0 = 0; ovf_exp1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(10, tx_bit.size());
    repeat (10) @(negedge clk);
    check("t6 hunt after reset", locked0, 0);
    check("t6 no spurious write", act0.size() + act1.size(), 0);
    clear_tx();

    // 4: 2-symbol frames fall back to hunt, then relock
    add_bits(SW, 8); add_sym(8'h06, 0); add_sym(8'h09, 0); add_sym(8'h0F, 0); add_bits(SW, 8);
    start_scn();
    send(0, tx_bit.size());
    end_scn("t4");
    check("t4 frame write count", act1.size(), 2);
    check("t4 frame first", act1[0], 8'h06);
    check("t4 frame second", act1[1], 8'h09);
    check("t4 lock dropped once", lk1_falls, 1);
    check("t4 relocked", locked1, 1);
    clear_tx();

    // 5: bit periods alternating 3 and 5 clocks
    jit_on = 1;
    add_bits(SW, 8); add_sym(8'h0A, 0);
    start_scn();
    send(0, tx_bit.size());
    end_scn("t5");
    check("t5 write count", act0.size(), 1);
    check("t5 sample", act0[0], 8'h0A);
    clear_tx();

    // randomized: noise, optional sync, random symbols with random backpressure
    for (int r = 0; r < 12; r++) begin
      add_bits($urandom, $urandom_range(0, 24));
      if ($urandom_range(0, 3) != 0) add_bits(SW, 8);
      for (int k = $urandom_range(1, 5); k > 0; k--)
        add_sym(8'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      start_scn();
      send(0, tx_bit.size());
      end_scn($sformatf("rand%0d", r));
      clear_tx();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
